// File: rtl/gate_stim_seq.sv
// Stimulus sequencer for a 2-input AND gate: walks AB through four patterns, samples the
// gate result at the end of each hold window and counts mismatches.
module gate_stim_seq #(
  parameter int unsigned HOLD_CYCLES = 50,
  parameter int unsigned ERR_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             gray_mode,
  input  logic             x_in,
  output logic             a_out,
  output logic             b_out,
  output logic             busy,
  output logic             done,
  output logic [ERR_W-1:0] err_cnt,
  output logic             pass
);

  localparam int unsigned HoldW = $clog2(HOLD_CYCLES);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrive = 2'd1,
    StFin   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       step_q, step_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             gray_q, gray_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic hold_last;
  logic mismatch;
  logic err_full;

  // Gray order 00,01,11,10 is the binary index with bit 0 xor-ed by bit 1.
  function automatic logic [1:0] pattern(input logic [1:0] idx, input logic gray);
    return gray ? {idx[1], idx[1] ^ idx[0]} : idx;
  endfunction

  assign hold_last = (hold_q == HoldLast);
  assign mismatch  = (x_in != (a_q & b_q));
  assign err_full  = &err_q;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    hold_d  = hold_q;
    gray_d  = gray_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StDrive;
          step_d     = 2'd0;
          hold_d     = '0;
          err_d      = '0;
          pass_d     = 1'b0;
          gray_d     = gray_mode;
          {a_d, b_d} = pattern(2'd0, gray_mode);
          busy_d     = 1'b1;
        end
      end
      StDrive: begin
        if (hold_last) begin
          hold_d = '0;
          if (mismatch && !err_full) begin
            err_d = err_q + ERR_W'(1);
          end
          if (step_q == 2'd3) begin
            state_d    = StFin;
            step_d     = 2'd0;
            {a_d, b_d} = 2'b00;
            done_d     = 1'b1;
            // Verdict includes the final sample taken on this same edge.
            pass_d     = (err_d == '0);
          end else begin
            step_d     = step_q + 2'd1;
            {a_d, b_d} = pattern(step_q + 2'd1, gray_q);
          end
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      StFin: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      step_q  <= 2'd0;
      hold_q  <= '0;
      gray_q  <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      hold_q  <= hold_d;
      gray_q  <= gray_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
    end
  end

  assign a_out   = a_q;
  assign b_out   = b_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err_cnt = err_q;
  assign pass    = pass_q;

endmodule

// File: tb/tb_gate_stim_seq.sv
// Bench for gate_stim_seq: a run-level reference model checked every cycle against two
// instances (4-bit and 1-bit mismatch counters), plus directed runs with literal expectations.
module tb_gate_stim_seq;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst_n, start, gray_mode, x_in;
  logic       a_out, b_out, busy, done, pass;
  logic [3:0] err_cnt;
  logic       a1, b1, busy1, done1, pass1;
  logic [0:0] err1;

  int n_checks = 0;
  int n_err    = 0;
  int x_mode   = 0;  // 0 ideal AND, 1 stuck-1, 2 stuck-0, 3 random
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  gate_stim_seq #(.HOLD_CYCLES(H), .ERR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .gray_mode(gray_mode), .x_in(x_in),
    .a_out(a_out), .b_out(b_out), .busy(busy), .done(done), .err_cnt(err_cnt), .pass(pass)
  );

  gate_stim_seq #(.HOLD_CYCLES(H), .ERR_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .gray_mode(gray_mode), .x_in(x_in),
    .a_out(a1), .b_out(b1), .busy(busy1), .done(done1), .err_cnt(err1), .pass(pass1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Gate under test, modelled after the registered stimulus settles.
  initial begin
    x_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (x_mode)
        0:       x_in = a_out & b_out;
        1:       x_in = 1'b1;
        2:       x_in = 1'b0;
        default: x_in = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Reference model: phase (0 idle, 1 drive, 2 fin) and cycle index within the drive window.
  logic [1:0] bin_ord [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic [1:0] gray_ord[4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int m_phase = 0;
  int m_t     = 0;
  bit m_gray  = 1'b0;
  int m_err4  = 0;
  int m_err1  = 0;
  bit m_pass4 = 1'b0;
  bit m_pass1 = 1'b0;

  function automatic logic [1:0] exp_ab();
    if (m_phase != 1) return 2'b00;
    return m_gray ? gray_ord[m_t / H] : bin_ord[m_t / H];
  endfunction

  always @(posedge clk) begin
    logic [1:0] ab;
    if (!rst_n) begin
      m_phase = 0; m_t = 0; m_err4 = 0; m_err1 = 0; m_pass4 = 0; m_pass1 = 0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_phase = 1; m_t = 0; m_err4 = 0; m_err1 = 0; m_pass4 = 0; m_pass1 = 0;
          m_gray = gray_mode;
        end
        1: begin
          if (m_t % H == H - 1) begin
            ab = exp_ab();
            if (x_in !== (ab[1] & ab[0])) begin
              if (m_err4 < 15) m_err4++;
              if (m_err1 < 1) m_err1++;
            end
          end
          m_t++;
          if (m_t == 4 * H) begin
            m_phase = 2;
            m_pass4 = (m_err4 == 0);
            m_pass1 = (m_err1 == 0);
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [1:0] ab;
      ab = exp_ab();
      check("a_out", a_out, ab[1]);
      check("b_out", b_out, ab[0]);
      check("busy", busy, m_phase != 0);
      check("done", done, m_phase == 2);
      check("err_cnt", err_cnt, m_err4);
      check("pass", pass, m_pass4);
      check("a_out_w1", a1, ab[1]);
      check("b_out_w1", b1, ab[0]);
      check("busy_w1", busy1, m_phase != 0);
      check("done_w1", done1, m_phase == 2);
      check("err_cnt_w1", err1, m_err1);
      check("pass_w1", pass1, m_pass1);
    end
  end

  // One start-to-idle run, recording busy length, done count and the first 16 AB values.
  task automatic run_one(input bit g, input int xm, input int start_at, output int busy_n,
                         output int done_n, output logic [31:0] trace, output int e4,
                         output int e1, output bit p4, output bit p1);
    bit finished = 1'b0;
    busy_n = 0; done_n = 0; trace = '0; e4 = -1; e1 = -1; p4 = 0; p1 = 0;
    @(posedge clk); #1;
    gray_mode = g; x_mode = xm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; gray_mode = ~g;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (k == start_at) start = 1'b1;
      if (k == start_at + 1) start = 1'b0;
      if (busy) busy_n++;
      if (busy && k < 16) trace = {trace[29:0], a_out, b_out};
      if (done) begin
        done_n++; e4 = int'(err_cnt); e1 = int'(err1); p4 = pass; p1 = pass1;
      end
      if (!busy) begin
        finished = 1'b1;
        break;
      end
    end
    check("run_terminates", finished, 1'b1);
    start = 1'b0;
  endtask

  initial begin
    int          bn, dn, e4, e1;
    logic [31:0] tr;
    bit          p4, p1;

    rst_n = 1'b0; start = 1'b1; gray_mode = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    check("rst_busy", busy, 1'b0);
    check("rst_err", err_cnt, 4'd0);
    check("rst_pass", pass, 1'b0);
    rst_n = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("idle_busy", busy, 1'b0);

    run_one(1'b0, 0, 6, bn, dn, tr, e4, e1, p4, p1);
    check("bin_busy_len", bn, 17);
    check("bin_done_cnt", dn, 1);
    check("bin_trace", tr, 32'h0055_AAFF);
    check("bin_err", e4, 0);
    check("bin_pass", p4, 1'b1);

    run_one(1'b1, 0, -5, bn, dn, tr, e4, e1, p4, p1);
    check("gray_trace", tr, 32'h0055_FFAA);
    check("gray_pass", p4, 1'b1);
    check("gray_busy_len", bn, 17);

    run_one(1'b0, 1, -5, bn, dn, tr, e4, e1, p4, p1);
    check("stuck1_err", e4, 3);
    check("stuck1_pass", p4, 1'b0);
    check("stuck1_err_w1", e1, 1);
    check("stuck1_pass_w1", p1, 1'b0);

    // Abort during step 2.
    @(posedge clk); #1;
    gray_mode = 1'b0; x_mode = 0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_abort_ab", {a_out, b_out}, 2'b10);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_ab", {a_out, b_out}, 2'b00);
    check("abort_done", done, 1'b0);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("abort_no_done", done, 1'b0);
    end

    run_one(1'b0, 0, -5, bn, dn, tr, e4, e1, p4, p1);
    check("post_abort_len", bn, 17);
    check("post_abort_done", dn, 1);
    check("post_abort_pass", p4, 1'b1);

    for (int c = 0; c < 2500; c++) begin
      @(posedge clk); #1;
      rst_n     = ($urandom_range(0, 199) != 0);
      start     = ($urandom_range(0, 5) == 0);
      gray_mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 30) == 0) x_mode = $urandom_range(0, 3);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/gate_stim_seq.md
GATE_STIM_SEQ -- requirements
Module: gate_stim_seq

Interface
REQ-001 Parameter HOLD_CYCLES, default 50, meaning: clock cycles each input pattern is held; legal range 2..65535.
REQ-002 Parameter ERR_W, default 4, meaning: width of the mismatch counter.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset; synchronous, active-low.
REQ-005 Port start  input  1  request to run one full stimulus sequence.
REQ-006 Port gray_mode  input  1  pattern order select: 0 = binary, 1 = Gray.
REQ-007 Port x_in  input  1  result returned by the downstream 2-input AND gate under test.
REQ-008 Port a_out  output  1  stimulus driven to gate input A.
REQ-009 Port b_out  output  1  stimulus driven to gate input B.
REQ-010 Port busy  output  1  high while a sequence is in progress.
REQ-011 Port done  output  1  one-cycle pulse at sequence completion.
REQ-012 Port err_cnt  output  ERR_W  count of mismatching samples in the last or current run.
REQ-013 Port pass  output  1  high when the last completed run had zero mismatches.

Function
REQ-014 The FSM SHALL have three states: IDLE, DRIVE, FIN.
REQ-015 In IDLE with start=1, the block SHALL load step=0 and hold=0, clear err_cnt and pass, latch gray_mode, and enter DRIVE on the next edge.
REQ-016 start SHALL be ignored in DRIVE and FIN; gray_mode SHALL be ignored except at the accepting edge.
REQ-017 In DRIVE, {a_out,b_out} SHALL follow the step index: binary order 00,01,10,11; Gray order 00,01,11,10.
REQ-018 In DRIVE, hold SHALL count 0..HOLD_CYCLES-1; at HOLD_CYCLES-1, hold SHALL wrap to 0 and step SHALL advance.
REQ-019 x_in SHALL be sampled only in the cycle where hold = HOLD_CYCLES-1 and compared with a_out & b_out.
REQ-020 Each mismatch SHALL increment err_cnt by 1, saturating at all-ones with no wrap.
REQ-021 After the sample at step 3, the FSM SHALL enter FIN; total DRIVE duration SHALL be exactly 4*HOLD_CYCLES cycles.
REQ-022 In FIN, done SHALL be 1 for exactly one cycle and pass SHALL be set to (final err_cnt == 0); the FSM SHALL then return to IDLE.
REQ-023 busy SHALL be 1 in DRIVE and FIN and 0 in IDLE.
REQ-024 In IDLE and FIN, a_out and b_out SHALL be 0.
REQ-025 err_cnt and pass SHALL hold their values in IDLE until the next accepted start.
REQ-026 A start asserted in the same cycle as done SHALL be ignored; a new run SHALL begin only from IDLE.
REQ-027 All outputs SHALL be registered; no output SHALL depend combinationally on any input.

Reset
REQ-028 With rst_n=0 at a rising edge, the next state SHALL be IDLE, regardless of the current state.
REQ-029 Under reset, a_out, b_out, busy, done and pass SHALL be 0, err_cnt SHALL be 0, and the step and hold counters SHALL be 0.
REQ-030 Reset asserted mid-run SHALL abort the run with no done pulse; start SHALL be ignored while rst_n=0.

Verification
REQ-031 Reset: hold rst_n=0 for 2 cycles with start=1 -> all outputs 0; busy stays 0 after release until start is applied.
REQ-032 HOLD_CYCLES=4, gray_mode=0, x_in ideal AND -> AB=00,01,10,11 for 4 cycles each; busy for 17 cycles; done pulses once; err_cnt=0; pass=1.
REQ-033 HOLD_CYCLES=4, gray_mode=1, x_in ideal -> AB=00,01,11,10; pass=1.
REQ-034 HOLD_CYCLES=4, x_in stuck at 1 -> err_cnt=3 at done, pass=0; with ERR_W=1 -> err_cnt=1 (saturated), pass=0.
REQ-035 start pulsed at cycle 6 of a run -> ignored; sequence timing unchanged.
REQ-036 rst_n=0 during step 2 -> next cycle: IDLE, a_out=b_out=0, busy=0, no done pulse; a subsequent start runs a full, clean sequence.
